// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the IF/ID and ID/EX registers: load-use, HI/LO and branch redirect.
// Latency: stall/flush are combinational from inputs and state; md_busy and stall_cycles are registered.
// Backpressure: a hazard holds F and D and bubbles E; a taken branch overrides any stall.
module pipeline_hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic             uses_rt_d,
    input  logic             hilo_read_d,
    input  logic             md_start_d,
    input  logic [4:0]       write_reg_e,
    input  logic             reg_write_e,
    input  logic             mem_to_reg_e,
    input  logic             md_start_e,
    input  logic             branch_taken_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int MD_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

    typedef enum logic {IDLE, MD_BUSY} state_t;

    state_t          state;
    logic [MD_W-1:0] md_cnt;
    logic            load_use;
    logic            md_hazard;

    assign load_use  = mem_to_reg_e & reg_write_e & (write_reg_e != 5'd0) &
                       ((write_reg_e == rs_d) | (uses_rt_d & (write_reg_e == rt_d)));
    assign md_hazard = (hilo_read_d | md_start_d) & (md_busy | md_start_e);

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!rst) begin
            // A taken branch squashes D, so any hazard D carried is moot.
            if (branch_taken_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (load_use || md_hazard) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            md_cnt  <= '0;
            md_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start_e) begin
                        state   <= MD_BUSY;
                        md_cnt  <= MD_W'(MD_LATENCY - 1);
                        md_busy <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (md_start_e) begin
                        md_cnt <= MD_W'(MD_LATENCY - 1);
                    end else if (md_cnt == '0) begin
                        state   <= IDLE;
                        md_busy <= 1'b0;
                    end else begin
                        md_cnt <= md_cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    md_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall_d && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: a CNT_W=16 instance and a CNT_W=3 instance share one stimulus stream.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_d, rt_d, write_reg_e;
    logic        uses_rt_d, hilo_read_d, md_start_d;
    logic        reg_write_e, mem_to_reg_e, md_start_e, branch_taken_e;
    logic        stall_f, stall_d, flush_d, flush_e, md_busy;
    logic [15:0] stall_cycles;
    logic        s_stall_f, s_stall_d, s_flush_d, s_flush_e, s_md_busy;
    logic [2:0]  s_stall_cycles;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .uses_rt_d(uses_rt_d),
        .hilo_read_d(hilo_read_d), .md_start_d(md_start_d), .write_reg_e(write_reg_e),
        .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .md_start_e(md_start_e),
        .branch_taken_e(branch_taken_e), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .flush_e(flush_e), .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .uses_rt_d(uses_rt_d),
        .hilo_read_d(hilo_read_d), .md_start_d(md_start_d), .write_reg_e(write_reg_e),
        .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .md_start_e(md_start_e),
        .branch_taken_e(branch_taken_e), .stall_f(s_stall_f), .stall_d(s_stall_d),
        .flush_d(s_flush_d), .flush_e(s_flush_e), .md_busy(s_md_busy),
        .stall_cycles(s_stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks {stall_f, stall_d, flush_d, flush_e} as one 4-bit vector.
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, stall_f, stall_d, flush_d, flush_e}, {28'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        rs_d = 5'd0; rt_d = 5'd0; uses_rt_d = 1'b0; hilo_read_d = 1'b0; md_start_d = 1'b0;
        write_reg_e = 5'd0; reg_write_e = 1'b0; mem_to_reg_e = 1'b0;
        md_start_e = 1'b0; branch_taken_e = 1'b0;
    endtask

    task automatic set_load_use();
        clear_in();
        mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd8; rs_d = 5'd8;
    endtask

    initial begin
        rst = 1'b1;
        set_load_use();
        #1;
        chk_ctl("ctl_forced_in_reset", 4'b0000);
        tick();
        chk("busy_after_reset", {31'd0, md_busy}, 32'd0);
        chk("cnt_after_reset", {16'd0, stall_cycles}, 32'd0);

        // load-use on rs
        rst = 1'b0;
        #1;
        chk_ctl("load_use_rs", 4'b1101);
        tick();
        clear_in();
        #1;
        chk_ctl("load_use_one_cycle", 4'b0000);
        chk("cnt_after_load_use", {16'd0, stall_cycles}, 32'd1);

        // load to $zero never stalls
        mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd0; rs_d = 5'd0;
        #1;
        chk_ctl("zero_reg_no_stall", 4'b0000);

        // rt only matters when the instruction reads rt
        clear_in();
        mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd9; rs_d = 5'd3; rt_d = 5'd9;
        #1;
        chk_ctl("rt_unused_no_stall", 4'b0000);
        uses_rt_d = 1'b1;
        #1;
        chk_ctl("load_use_rt", 4'b1101);
        tick();
        chk("cnt_after_rt", {16'd0, stall_cycles}, 32'd2);

        // branch overrides a simultaneous load-use
        set_load_use();
        branch_taken_e = 1'b1;
        #1;
        chk_ctl("branch_over_load_use", 4'b0011);
        tick();
        chk("cnt_branch_unchanged", {16'd0, stall_cycles}, 32'd2);

        // non-load writer does not stall
        set_load_use();
        mem_to_reg_e = 1'b0;
        #1;
        chk_ctl("alu_writer_no_stall", 4'b0000);

        // mflo in D while mult issues from E
        clear_in();
        md_start_e = 1'b1; hilo_read_d = 1'b1;
        #1;
        chk_ctl("md_issue_stall", 4'b1101);
        tick();
        md_start_e = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk($sformatf("md_busy_c%0d", k), {31'd0, md_busy}, 32'd1);
            chk_ctl($sformatf("md_stall_c%0d", k), 4'b1101);
            tick();
        end
        chk("md_busy_drop", {31'd0, md_busy}, 32'd0);
        chk_ctl("md_mflo_proceeds", 4'b0000);
        chk("cnt_after_md", {16'd0, stall_cycles}, 32'd7);

        // reset during the second busy cycle aborts the operation
        clear_in();
        md_start_e = 1'b1;
        tick();
        md_start_e = 1'b0;
        tick();
        chk("busy_second_cycle", {31'd0, md_busy}, 32'd1);
        rst = 1'b1;
        hilo_read_d = 1'b1;
        #1;
        chk_ctl("md_hazard_masked_by_rst", 4'b0000);
        tick();
        rst = 1'b0;
        #1;
        chk("busy_after_abort", {31'd0, md_busy}, 32'd0);
        chk("cnt_after_abort", {16'd0, stall_cycles}, 32'd0);
        chk_ctl("no_stall_after_abort", 4'b0000);

        // md_start_d behind an issuing mult, then a re-issue restarts the count
        clear_in();
        md_start_e = 1'b1; md_start_d = 1'b1;
        #1;
        chk_ctl("md_start_d_hazard", 4'b1101);
        tick();
        clear_in();
        #1;
        chk_ctl("busy_no_d_hazard", 4'b0000);
        tick();
        md_start_e = 1'b1;
        tick();
        md_start_e = 1'b0;
        tick();
        tick();
        tick();
        chk("restart_busy_last", {31'd0, md_busy}, 32'd1);
        tick();
        chk("restart_busy_done", {31'd0, md_busy}, 32'd0);
        chk("cnt_before_sat", {16'd0, stall_cycles}, 32'd1);

        // ten stall cycles: 3-bit counter saturates at 7
        set_load_use();
        for (int k = 0; k < 6; k++) tick();
        chk("sat_reaches_max", {29'd0, s_stall_cycles}, 32'd7);
        for (int k = 0; k < 4; k++) tick();
        chk("sat_holds_max", {29'd0, s_stall_cycles}, 32'd7);
        chk("wide_cnt_no_sat", {16'd0, stall_cycles}, 32'd11);
        clear_in();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
